// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of the three requester ports (debug, data, fetch) and the shared memory port
// seen by the RV32I memory arbiter.
interface rv32i_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                    i_dbg_req;
  logic                    i_dbg_wr_en;
  logic [ADDR_WIDTH-1:0]   i_dbg_addr;
  logic [31:0]             i_dbg_wdata;
  logic [31:0]             o_dbg_rdata;
  logic                    o_dbg_ack;

  logic                    i_data_req;
  logic                    i_data_wr_en;
  logic [ADDR_WIDTH-1:0]   i_data_addr;
  logic [31:0]             i_data_wdata;
  logic [3:0]              i_data_mask;
  logic [31:0]             o_data_rdata;
  logic                    o_data_ack;

  logic                    i_inst_req;
  logic [ADDR_WIDTH-1:0]   i_inst_addr;
  logic [31:0]             o_inst_data;
  logic                    o_inst_ack;

  logic                    o_mem_en;
  logic                    o_mem_wr_en;
  logic [ADDR_WIDTH-3:0]   o_mem_addr;
  logic [31:0]             o_mem_wdata;
  logic [3:0]              o_mem_mask;
  logic [31:0]             i_mem_rdata;

  logic                    o_err;
  logic                    o_busy;

  // Arbiter side
  modport slave (
    input  i_dbg_req, i_dbg_wr_en, i_dbg_addr, i_dbg_wdata,
    output o_dbg_rdata, o_dbg_ack,
    input  i_data_req, i_data_wr_en, i_data_addr, i_data_wdata, i_data_mask,
    output o_data_rdata, o_data_ack,
    input  i_inst_req, i_inst_addr,
    output o_inst_data, o_inst_ack,
    output o_mem_en, o_mem_wr_en, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  i_mem_rdata,
    output o_err, o_busy
  );

  // Requester / memory-model side
  modport master (
    output i_dbg_req, i_dbg_wr_en, i_dbg_addr, i_dbg_wdata,
    input  o_dbg_rdata, o_dbg_ack,
    output i_data_req, i_data_wr_en, i_data_addr, i_data_wdata, i_data_mask,
    input  o_data_rdata, o_data_ack,
    output i_inst_req, i_inst_addr,
    input  o_inst_data, o_inst_ack,
    input  o_mem_en, o_mem_wr_en, o_mem_addr, o_mem_wdata, o_mem_mask,
    output i_mem_rdata,
    input  o_err, o_busy
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Two-state arbiter sharing one synchronous memory between debug, data and fetch ports:
// debug has absolute priority, data and fetch alternate when both request.
module rv32i_mem_arbiter #(
  parameter int MEMORY_DEPTH = 49152,
  parameter int ADDR_WIDTH   = 32
) (
  input logic                i_clk,
  input logic                i_rst_n,
  rv32i_mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SEL_DBG = 2'd0, SEL_DATA = 2'd1, SEL_INST = 2'd2, SEL_NONE = 2'd3} sel_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

  state_t                state_reg, state_next;
  sel_t                  winner_reg;
  logic                  wr_reg, err_reg;
  logic                  last_inst_reg;
  sel_t                  sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wr;
  logic [31:0]           sel_wdata;
  logic [3:0]            sel_mask;
  logic                  sel_err;
  logic                  mem_en, mem_wr;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_mask;
  logic                  in_wait;
  logic [31:0]           resp_data;
  logic [2:0]            ack_vec;
  logic [31:0]           rdata_out [3];

  // last_inst_reg = 1 means fetch was granted last, so data wins the next tie
  always_comb begin
    sel = SEL_NONE;
    if (bus.i_dbg_req)                          sel = SEL_DBG;
    else if (bus.i_data_req && bus.i_inst_req)  sel = last_inst_reg ? SEL_DATA : SEL_INST;
    else if (bus.i_data_req)                    sel = SEL_DATA;
    else if (bus.i_inst_req)                    sel = SEL_INST;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wr    = 1'b0;
    sel_wdata = 32'd0;
    sel_mask  = 4'b0000;
    case (sel)
      SEL_DBG: begin
        sel_addr  = bus.i_dbg_addr;
        sel_wr    = bus.i_dbg_wr_en;
        sel_wdata = bus.i_dbg_wr_en ? bus.i_dbg_wdata : 32'd0;
        sel_mask  = bus.i_dbg_wr_en ? 4'b1111 : 4'b0000;
      end
      SEL_DATA: begin
        sel_addr  = bus.i_data_addr;
        sel_wr    = bus.i_data_wr_en;
        sel_wdata = bus.i_data_wr_en ? bus.i_data_wdata : 32'd0;
        sel_mask  = bus.i_data_wr_en ? bus.i_data_mask : 4'b0000;
      end
      SEL_INST: sel_addr = bus.i_inst_addr;
      default: ;
    endcase
    sel_err = (sel != SEL_NONE) && ({1'b0, sel_addr} >= DEPTH_LIMIT);
  end

  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'd0;
    mem_mask   = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (i_rst_n && sel != SEL_NONE) begin
          state_next = WAIT;
          // Out-of-range accesses still take the WAIT slot, but never touch memory
          if (!sel_err) begin
            mem_en    = 1'b1;
            mem_wr    = sel_wr;
            mem_addr  = sel_addr[ADDR_WIDTH-1:2];
            mem_wdata = sel_wdata;
            mem_mask  = sel_mask;
          end
        end
      end
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      winner_reg    <= SEL_NONE;
      wr_reg        <= 1'b0;
      err_reg       <= 1'b0;
      last_inst_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && sel != SEL_NONE) begin
        winner_reg <= sel;
        wr_reg     <= sel_wr;
        err_reg    <= sel_err;
        if (sel == SEL_DATA)      last_inst_reg <= 1'b0;
        else if (sel == SEL_INST) last_inst_reg <= 1'b1;
      end
    end
  end

  // Gating with i_rst_n suppresses the ack of a WAIT cycle that is being reset
  assign in_wait   = i_rst_n && (state_reg == WAIT);
  assign resp_data = (wr_reg || err_reg) ? 32'd0 : bus.i_mem_rdata;

  for (genvar gi = 0; gi < 3; gi++) begin : g_port
    logic [31:0] rdata_reg;
    assign ack_vec[gi] = in_wait && (winner_reg == sel_t'(2'(gi)));
    always_ff @(posedge i_clk) begin
      if (!i_rst_n)         rdata_reg <= 32'd0;
      else if (ack_vec[gi]) rdata_reg <= resp_data;
    end
    assign rdata_out[gi] = ack_vec[gi] ? resp_data : rdata_reg;
  end

  assign bus.o_dbg_ack    = ack_vec[0];
  assign bus.o_dbg_rdata  = rdata_out[0];
  assign bus.o_data_ack   = ack_vec[1];
  assign bus.o_data_rdata = rdata_out[1];
  assign bus.o_inst_ack   = ack_vec[2];
  assign bus.o_inst_data  = rdata_out[2];
  assign bus.o_mem_en     = mem_en;
  assign bus.o_mem_wr_en  = mem_wr;
  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_wdata  = mem_wdata;
  assign bus.o_mem_mask   = mem_mask;
  assign bus.o_err        = in_wait && err_reg;
  assign bus.o_busy       = in_wait;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for the memory arbiter: a small word memory answers one cycle after
// o_mem_en, and each scenario task checks grants, acks and returned data.
module tb_rv32i_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:16383];

  rv32i_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  rv32i_mem_arbiter #(.MEMORY_DEPTH(49152), .ADDR_WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Memory model: preloaded while reset is low, read data valid the cycle after o_mem_en
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[4]     <= 32'h00500093;
      mem[8]     <= 32'hA5A50008;
      mem[9]     <= 32'hA5A50009;
      mem[12]    <= 32'hA5A5000C;
      mem[1025]  <= 32'h00000000;
      mem[12287] <= 32'h0BADF00D;
      bus.i_mem_rdata <= 32'd0;
    end else if (bus.o_mem_en) begin
      if (bus.o_mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (bus.o_mem_mask[b]) mem[bus.o_mem_addr[13:0]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
      end else begin
        bus.i_mem_rdata <= mem[bus.o_mem_addr[13:0]];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h10;
    step(); step();
    checks++; if (bus.o_mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got=%0h exp=0", bus.o_mem_en); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", bus.o_busy); end
    checks++; if ({bus.o_dbg_ack, bus.o_data_ack, bus.o_inst_ack, bus.o_err} !== 4'b0000) begin errors++; $display("FAIL rst_acks got=%b exp=0000", {bus.o_dbg_ack, bus.o_data_ack, bus.o_inst_ack, bus.o_err}); end
    checks++; if ((bus.o_dbg_rdata | bus.o_data_rdata | bus.o_inst_data) !== 32'd0) begin errors++; $display("FAIL rst_rdata got=%h/%h/%h exp=0", bus.o_dbg_rdata, bus.o_data_rdata, bus.o_inst_data); end
    $display("txn reset held: outputs idle");
    bus.i_inst_req = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_inst_read();
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h10;
    #1;
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 30'h4) begin errors++; $display("FAIL inst_grant got en=%0h addr=%h exp en=1 addr=4", bus.o_mem_en, bus.o_mem_addr); end
    checks++; if (bus.o_mem_wr_en !== 1'b0 || bus.o_mem_mask !== 4'b0000) begin errors++; $display("FAIL inst_rd_ctrl got wr=%0h mask=%b exp wr=0 mask=0000", bus.o_mem_wr_en, bus.o_mem_mask); end
    step();
    checks++; if (bus.o_inst_ack !== 1'b1 || bus.o_inst_data !== 32'h00500093) begin errors++; $display("FAIL inst_ack got ack=%0h data=%h exp ack=1 data=00500093", bus.o_inst_ack, bus.o_inst_data); end
    checks++; if (bus.o_busy !== 1'b1 || bus.o_mem_en !== 1'b0) begin errors++; $display("FAIL inst_wait got busy=%0h en=%0h exp busy=1 en=0", bus.o_busy, bus.o_mem_en); end
    $display("txn inst read addr=00000010 data=%h", bus.o_inst_data);
    bus.i_inst_req = 1'b0;
    step();
    checks++; if (bus.o_inst_ack !== 1'b0 || bus.o_inst_data !== 32'h00500093 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL inst_hold got ack=%0h data=%h busy=%0h exp ack=0 data=00500093 busy=0", bus.o_inst_ack, bus.o_inst_data, bus.o_busy); end
  endtask

  task automatic test_data_write();
    bus.i_data_req = 1'b1; bus.i_data_wr_en = 1'b1; bus.i_data_addr = 32'h1004;
    bus.i_data_wdata = 32'hDEADBEEF; bus.i_data_mask = 4'b0011;
    #1;
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_wr_en !== 1'b1 || bus.o_mem_addr !== 30'h401) begin errors++; $display("FAIL dwr_grant got en=%0h wr=%0h addr=%h exp 1 1 401", bus.o_mem_en, bus.o_mem_wr_en, bus.o_mem_addr); end
    checks++; if (bus.o_mem_mask !== 4'b0011 || bus.o_mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dwr_data got mask=%b wdata=%h exp 0011 DEADBEEF", bus.o_mem_mask, bus.o_mem_wdata); end
    step();
    checks++; if (bus.o_data_ack !== 1'b1 || bus.o_data_rdata !== 32'd0 || bus.o_inst_ack !== 1'b0) begin errors++; $display("FAIL dwr_ack got ack=%0h rdata=%h iack=%0h exp 1 0 0", bus.o_data_ack, bus.o_data_rdata, bus.o_inst_ack); end
    $display("txn data write addr=00001004 wdata=deadbeef mask=0011");
    bus.i_data_req = 1'b0; bus.i_data_wr_en = 1'b0;
    step();
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h1006; bus.i_data_mask = 4'b1111;
    #1;
    checks++; if (bus.o_mem_addr !== 30'h401 || bus.o_mem_mask !== 4'b0000 || bus.o_mem_wr_en !== 1'b0) begin errors++; $display("FAIL drd_grant got addr=%h mask=%b wr=%0h exp 401 0000 0", bus.o_mem_addr, bus.o_mem_mask, bus.o_mem_wr_en); end
    step();
    checks++; if (bus.o_data_ack !== 1'b1 || bus.o_data_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL drd_ack got ack=%0h rdata=%h exp 1 0000BEEF", bus.o_data_ack, bus.o_data_rdata); end
    $display("txn data read addr=00001006 data=%h", bus.o_data_rdata);
    bus.i_data_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int dc = 0;
    int ic = 0;
    apply_reset();
    bus.i_data_req = 1'b1; bus.i_data_wr_en = 1'b0; bus.i_data_addr = 32'h20;
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h24;
    #1;
    for (int c = 0; c < 8; c++) begin
      logic exp_d, exp_i;
      exp_d = (c == 1 || c == 5);
      exp_i = (c == 3 || c == 7);
      checks++; if (bus.o_data_ack !== exp_d || bus.o_inst_ack !== exp_i) begin errors++; $display("FAIL rr_cycle%0d got dack=%0h iack=%0h exp %0h %0h", c, bus.o_data_ack, bus.o_inst_ack, exp_d, exp_i); end
      if (c == 0 || c == 2) begin
        checks++; if (bus.o_mem_addr !== ((c == 0) ? 30'd8 : 30'd9)) begin errors++; $display("FAIL rr_addr%0d got=%h exp=%h", c, bus.o_mem_addr, (c == 0) ? 30'd8 : 30'd9); end
      end
      if (bus.o_data_ack === 1'b1) begin
        dc++;
        checks++; if (bus.o_data_rdata !== 32'hA5A50008) begin errors++; $display("FAIL rr_drdata got=%h exp=A5A50008", bus.o_data_rdata); end
        $display("txn rr cycle %0d data ack data=%h", c, bus.o_data_rdata);
      end
      if (bus.o_inst_ack === 1'b1) begin
        ic++;
        checks++; if (bus.o_inst_data !== 32'hA5A50009) begin errors++; $display("FAIL rr_idata got=%h exp=A5A50009", bus.o_inst_data); end
        $display("txn rr cycle %0d inst ack data=%h", c, bus.o_inst_data);
      end
      step();
    end
    bus.i_data_req = 1'b0; bus.i_inst_req = 1'b0;
    checks++; if (dc != 2 || ic != 2) begin errors++; $display("FAIL rr_counts got data=%0d inst=%0d exp 2 2", dc, ic); end
    step();
  endtask

  task automatic test_debug_priority();
    apply_reset();
    bus.i_dbg_req = 1'b1; bus.i_dbg_wr_en = 1'b0; bus.i_dbg_addr = 32'h30;
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h20;
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h24;
    #1;
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus.o_dbg_ack !== c[0] || bus.o_data_ack !== 1'b0 || bus.o_inst_ack !== 1'b0) begin errors++; $display("FAIL dbg_cycle%0d got dbg=%0h data=%0h inst=%0h exp %0h 0 0", c, bus.o_dbg_ack, bus.o_data_ack, bus.o_inst_ack, c[0]); end
      if (c == 1) begin
        checks++; if (bus.o_dbg_rdata !== 32'hA5A5000C) begin errors++; $display("FAIL dbg_rdata got=%h exp=A5A5000C", bus.o_dbg_rdata); end
        $display("txn dbg read addr=00000030 data=%h", bus.o_dbg_rdata);
      end
      step();
    end
    bus.i_dbg_req = 1'b0;
    #1;
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 30'd8) begin errors++; $display("FAIL dbg_release got en=%0h addr=%h exp 1 8", bus.o_mem_en, bus.o_mem_addr); end
    step();
    checks++; if (bus.o_data_ack !== 1'b1) begin errors++; $display("FAIL dbg_core_ack got=%0h exp=1", bus.o_data_ack); end
    bus.i_data_req = 1'b0;
    step();
    checks++; if (bus.o_mem_addr !== 30'd9 || bus.o_mem_en !== 1'b1) begin errors++; $display("FAIL dbg_inst_grant got en=%0h addr=%h exp 1 9", bus.o_mem_en, bus.o_mem_addr); end
    step();
    // Debug and data arrive while the fetch is still in WAIT
    bus.i_inst_req = 1'b0;
    bus.i_dbg_req = 1'b1; bus.i_dbg_wr_en = 1'b1; bus.i_dbg_addr = 32'h40; bus.i_dbg_wdata = 32'hCAFEF00D;
    bus.i_data_req = 1'b1;
    #1;
    checks++; if (bus.o_inst_ack !== 1'b1 || bus.o_mem_en !== 1'b0 || bus.o_dbg_ack !== 1'b0) begin errors++; $display("FAIL dbg_no_preempt got iack=%0h en=%0h dack=%0h exp 1 0 0", bus.o_inst_ack, bus.o_mem_en, bus.o_dbg_ack); end
    step();
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_wr_en !== 1'b1 || bus.o_mem_addr !== 30'h10 || bus.o_mem_mask !== 4'b1111 || bus.o_mem_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL dbg_write got en=%0h wr=%0h addr=%h mask=%b wdata=%h exp 1 1 10 1111 CAFEF00D", bus.o_mem_en, bus.o_mem_wr_en, bus.o_mem_addr, bus.o_mem_mask, bus.o_mem_wdata); end
    step();
    checks++; if (bus.o_dbg_ack !== 1'b1 || bus.o_dbg_rdata !== 32'd0) begin errors++; $display("FAIL dbg_wr_ack got ack=%0h rdata=%h exp 1 0", bus.o_dbg_ack, bus.o_dbg_rdata); end
    $display("txn dbg write addr=00000040 wdata=cafef00d");
    bus.i_dbg_req = 1'b0; bus.i_dbg_wr_en = 1'b0; bus.i_data_req = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    bus.i_data_req = 1'b1; bus.i_data_wr_en = 1'b0; bus.i_data_addr = 32'd49148;
    #1;
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 30'd12287) begin errors++; $display("FAIL oor_last_grant got en=%0h addr=%h exp 1 2FFF", bus.o_mem_en, bus.o_mem_addr); end
    step();
    checks++; if (bus.o_data_ack !== 1'b1 || bus.o_err !== 1'b0 || bus.o_data_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL oor_last_ack got ack=%0h err=%0h rdata=%h exp 1 0 0BADF00D", bus.o_data_ack, bus.o_err, bus.o_data_rdata); end
    bus.i_data_addr = 32'd49152;
    step();
    checks++; if (bus.o_mem_en !== 1'b0 || bus.o_err !== 1'b0) begin errors++; $display("FAIL oor_grant got en=%0h err=%0h exp 0 0", bus.o_mem_en, bus.o_err); end
    step();
    checks++; if (bus.o_data_ack !== 1'b1 || bus.o_err !== 1'b1 || bus.o_data_rdata !== 32'd0 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL oor_ack got ack=%0h err=%0h rdata=%h busy=%0h exp 1 1 0 1", bus.o_data_ack, bus.o_err, bus.o_data_rdata, bus.o_busy); end
    $display("txn data read addr=0000c000 out of range err=%0h", bus.o_err);
    bus.i_data_req = 1'b0;
    step();
    checks++; if (bus.o_err !== 1'b0 || bus.o_data_rdata !== 32'd0) begin errors++; $display("FAIL oor_after got err=%0h rdata=%h exp 0 0", bus.o_err, bus.o_data_rdata); end
  endtask

  task automatic test_reset_in_wait();
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h10;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_inst_ack !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL rw_abort got ack=%0h busy=%0h exp 0 0", bus.o_inst_ack, bus.o_busy); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.o_inst_ack !== 1'b0 || bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 30'h4 || bus.o_inst_data !== 32'd0) begin errors++; $display("FAIL rw_regrant got ack=%0h en=%0h addr=%h data=%h exp 0 1 4 0", bus.o_inst_ack, bus.o_mem_en, bus.o_mem_addr, bus.o_inst_data); end
    step();
    checks++; if (bus.o_inst_ack !== 1'b1 || bus.o_inst_data !== 32'h00500093) begin errors++; $display("FAIL rw_ack got ack=%0h data=%h exp 1 00500093", bus.o_inst_ack, bus.o_inst_data); end
    $display("txn inst read after aborted access data=%h", bus.o_inst_data);
    bus.i_inst_req = 1'b0;
    step();
  endtask

  initial begin
    bus.i_dbg_req = 1'b0; bus.i_dbg_wr_en = 1'b0; bus.i_dbg_addr = '0; bus.i_dbg_wdata = '0;
    bus.i_data_req = 1'b0; bus.i_data_wr_en = 1'b0; bus.i_data_addr = '0; bus.i_data_wdata = '0; bus.i_data_mask = '0;
    bus.i_inst_req = 1'b0; bus.i_inst_addr = '0;
    test_reset();
    test_inst_read();
    test_data_write();
    test_round_robin();
    test_debug_priority();
    test_out_of_range();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_mem_arbiter.md
RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 49152, memory size in bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, requester byte-address width.
REQ-003 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_dbg_req / i_dbg_wr_en  input  1 each  debug/loader port request and write enable.
REQ-006 SHALL have port i_dbg_addr  input  ADDR_WIDTH; i_dbg_wdata  input  32; o_dbg_rdata  output  32; o_dbg_ack  output  1.
REQ-007 SHALL have port i_data_req / i_data_wr_en  input  1 each  core data port request and write enable.
REQ-008 SHALL have port i_data_addr  input  ADDR_WIDTH; i_data_wdata  input  32; i_data_mask  input  4  byte mask; o_data_rdata  output  32; o_data_ack  output  1.
REQ-009 SHALL have port i_inst_req  input  1; i_inst_addr  input  ADDR_WIDTH; o_inst_data  output  32; o_inst_ack  output  1  instruction fetch port (read-only).
REQ-010 SHALL have port o_mem_en / o_mem_wr_en  output  1 each  memory access strobe and write enable.
REQ-011 SHALL have port o_mem_addr  output  ADDR_WIDTH-2  word address; o_mem_wdata  output  32; o_mem_mask  output  4; i_mem_rdata  input  32, valid the cycle after o_mem_en.
REQ-012 SHALL have port o_err  output  1  out-of-range access pulse; o_busy  output  1  high while state is WAIT.

Function
REQ-013 SHALL implement an FSM with states IDLE and WAIT.
REQ-014 In IDLE with any request, SHALL select one winner, assert o_mem_en for exactly that cycle, latch the winner ID, and go to WAIT.
REQ-015 Priority: debug absolute over data and inst; data vs inst round-robin via a last-grant bit (simultaneous requests grant the one not granted last); after reset the last-grant bit favours data.
REQ-016 Debug writes SHALL drive o_mem_mask = 4'b1111; data writes drive i_data_mask; reads drive mask 4'b0000 and o_mem_wr_en = 0.
REQ-017 o_mem_addr SHALL equal the winner's byte address >> 2; byte-address bits [1:0] ignored.
REQ-018 In WAIT, SHALL pulse the winner's ack for one cycle, present i_mem_rdata on the winner's rdata (reads; 0 for writes), and return to IDLE.
REQ-019 Latency: request seen in IDLE at cycle N -> ack at cycle N+1; max throughput one access per 2 cycles.
REQ-020 Requesters hold req/addr/wdata stable until ack; a request still high in the cycle after ack SHALL be treated as a new access.
REQ-021 Rdata outputs SHALL hold their last value until the next ack of the same port.
REQ-022 Address >= MEMORY_DEPTH: o_mem_en SHALL stay 0, FSM still goes to WAIT, ack issued with rdata 0, o_err pulsed with that ack.
REQ-023 No request in IDLE: all memory outputs 0; FSM stays IDLE.
REQ-024 Debug request arriving while in WAIT SHALL not pre-empt; it wins the next IDLE cycle.

Reset
REQ-025 While i_rst_n = 0 at a clock edge: state -> IDLE, last-grant -> data-favoured, all acks, o_mem_en, o_mem_wr_en, o_err, o_busy -> 0, all rdata -> 0.
REQ-026 Reset during WAIT SHALL abort the access with no ack issued; requesters re-arbitrate after release.

Verification
REQ-027 Inst read 0x10, mem word 4 = 0x00500093 -> o_mem_en at N with o_mem_addr 4; o_inst_ack at N+1, o_inst_data 0x00500093.
REQ-028 Data write 0x1004, wdata 0xDEADBEEF, mask 4'b0011 -> o_mem_wr_en 1, o_mem_addr 0x401, o_mem_mask 4'b0011; o_data_ack next cycle, o_data_rdata 0.
REQ-029 Inst and data both held high 8 cycles after reset -> grants alternate data, inst, data, inst; 4 acks total, 2 per port.
REQ-030 Debug, data, inst all requesting -> debug granted every access opportunity while i_dbg_req held; core acks only after debug drops.
REQ-031 Data read address 49152 -> no o_mem_en; o_data_ack and o_err together, o_data_rdata 0.
REQ-032 i_rst_n low in WAIT cycle -> no ack that cycle or after; o_busy 0; fresh request after release acked with normal latency.
